instr_fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the single-cycle core's decode/execute stage. It generates sequential fetch addresses and issues one request at a time to an instruction memory with variable latency. Returned words are buffered, with their PC, in a small FIFO and handed downstream over a valid/ready handshake. Branch and jump redirects from the core flush the queue and restart fetch at the target.

---
 rtl/instr_fetch_queue.sv | 172 +++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetcher with a small PC-tagged
// FIFO feeding a valid/ready decode stage. One memory request is in flight
// at a time. A redirect flushes the queue and restarts fetch at the target.
// Optional build macro IFQ_PERF_EN adds saturating fetch/drop counters.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t           r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_addr;
  logic [31:0]      r_q_instr [DEPTH];
  logic [31:0]      r_q_pc    [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic        w_issue;
  logic        w_enq;
  logic        w_deq;
  logic        w_drop;
  logic [31:0] w_redirect_pc;
  logic [1:0]  w_unused_pc_lsb;

  // Saturating 16-bit increment for the event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Redirect targets are always word aligned; the low bits are dropped.
  assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = redirect_pc[1:0];

  // A new request is only launched when a queue slot is guaranteed free,
  // so the queue can never overflow.
  assign w_issue = (r_state == S_IDLE) && !reset && !redirect && (r_count < FULL_CNT);

  // Once issued, the request must be held until the memory acks it, even
  // if the stream it belongs to has been abandoned (DROP).
  assign mem_req  = w_issue || (r_state == S_WAIT) || (r_state == S_DROP);
  assign mem_addr = (r_state == S_IDLE) ? r_fetch_pc : r_req_addr;

  assign w_enq  = mem_ack && !redirect && (w_issue || (r_state == S_WAIT));
  assign w_deq  = instr_valid && instr_ready && !redirect;
  assign w_drop = mem_ack && ((r_state == S_DROP) || ((r_state == S_WAIT) && redirect));

  // Head outputs read as zero while the queue is empty.
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_q_instr[r_head] : 32'h0;
  assign instr_pc    = instr_valid ? r_q_pc[r_head]    : 32'h0;

  // Fetch FSM: IDLE launches requests, WAIT holds one, DROP retires a stale one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
          end else if (w_issue) begin
            if (mem_ack) begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
              r_req_addr <= r_fetch_pc;
              r_state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            r_state    <= mem_ack ? S_IDLE : S_DROP;
          end else if (mem_ack) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= S_IDLE;
          end
        end
        S_DROP: begin
          if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
          end
          if (mem_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect flushes ahead of any enq/deq.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: instruction word tagged with the address it came from.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_instr[r_tail] <= mem_rdata;
      r_q_pc[r_tail]    <= mem_addr;
    end
  end

`ifdef IFQ_PERF_EN
  logic [15:0] r_perf_fetch;
  logic [15:0] r_perf_drop;

  // Event counters: enqueued words and responses thrown away after a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch <= 16'h0;
      r_perf_drop  <= 16'h0;
    end else begin
      if (w_enq) begin
        r_perf_fetch <= sat_inc16(r_perf_fetch);
      end
      if (w_drop) begin
        r_perf_drop <= sat_inc16(r_perf_drop);
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue with a simple fixed-latency
// instruction memory model returning addr/4 as the instruction word.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef IFQ_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int r_lat    = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // Memory model: ack on the lat-th cycle a request is held.
  always @(posedge clk) begin
    if (reset || !mem_req || mem_ack) r_lat <= 0;
    else r_lat <= r_lat + 1;
  end
  assign mem_ack   = mem_req && (r_lat == lat - 1);
  assign mem_rdata = mem_addr >> 2;

  task automatic apply_reset(input int l);
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; instr_ready = 1'b0; lat = l;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; instr_ready = 1'b0; lat = 1;
    @(negedge clk); #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b want=0", mem_req); end
    reset = 1'b0; #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_req req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_zero_wait();
    apply_reset(1);
    instr_ready = 1'b1; #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL zw_first valid=%b req=%b addr=%h want 0/1/0", instr_valid, mem_req, mem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== 32'(i)) begin
        n_fail++; $display("FAIL zw_seq%0d valid=%b pc=%h instr=%h want 1/%h/%h", i, instr_valid, instr_pc, instr, 4 * i, i);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_req;
    n_req = 0;
    apply_reset(3);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_req && mem_ack) begin
        n_checks++;
        if (mem_addr !== 32'(4 * n_req)) begin
          n_fail++; $display("FAIL bp_addr%0d got=%h want=%h", n_req, mem_addr, 4 * n_req);
        end
        n_req++;
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (n_req != 4) begin n_fail++; $display("FAIL bp_nreq got=%0d want=4", n_req); end
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req got=%b want=0", mem_req); end
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== 32'(i)) begin
        n_fail++; $display("FAIL bp_drain%0d valid=%b pc=%h instr=%h want 1/%h/%h", i, instr_valid, instr_pc, instr, 4 * i, i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    found = 0;
    apply_reset(3);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_req && mem_addr == 32'h8 && !mem_ack) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rw_timeout got=0 want=1"); end
    @(negedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8 || mem_ack !== 1'b0 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL rw_wait req=%b addr=%h ack=%b valid=%b want 1/8/0/1", mem_req, mem_addr, mem_ack, instr_valid);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0; #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      n_fail++; $display("FAIL rw_drop valid=%b req=%b addr=%h want 0/1/8", instr_valid, mem_req, mem_addr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL rw_target valid=%b req=%b addr=%h want 0/1/100", instr_valid, mem_req, mem_addr);
    end
    instr_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (instr_valid) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found || instr_pc !== 32'h100 || instr !== 32'h40) begin
      n_fail++; $display("FAIL rw_first found=%0d pc=%h instr=%h want 1/100/40", found, instr_pc, instr);
    end
`ifdef IFQ_PERF_EN
    n_checks++;
    if (perf_drop_cnt !== 16'd1 || perf_fetch_cnt !== 16'd3) begin
      n_fail++; $display("FAIL rw_perf drop=%0d fetch=%0d want 1/3", perf_drop_cnt, perf_fetch_cnt);
    end
`endif
  endtask

  task automatic test_redirect_ack();
    bit found;
    found = 0;
    apply_reset(3);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_ack && mem_addr == 32'h4) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL ra_setup found=%0d valid=%b pc=%h want 1/1/0", found, instr_valid, instr_pc);
    end
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0; #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL ra_flush valid=%b req=%b addr=%h want 0/1/200", instr_valid, mem_req, mem_addr);
    end
    found = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (instr_valid) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found || instr_pc !== 32'h200 || instr !== 32'h80) begin
      n_fail++; $display("FAIL ra_first found=%0d pc=%h instr=%h want 1/200/80", found, instr_pc, instr);
    end
`ifdef IFQ_PERF_EN
    n_checks++;
    if (perf_drop_cnt !== 16'd1 || perf_fetch_cnt !== 16'd2) begin
      n_fail++; $display("FAIL ra_perf drop=%0d fetch=%0d want 1/2", perf_drop_cnt, perf_fetch_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    found = 0;
    apply_reset(3);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_req && mem_addr == 32'h8 && !mem_ack) begin found = 1; break; end
      @(negedge clk);
    end
    @(negedge clk); #1;
    n_checks++;
    if (!found || instr_valid !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      n_fail++; $display("FAIL rm_setup found=%0d valid=%b req=%b addr=%h want 1/1/1/8", found, instr_valid, mem_req, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rm_reset valid=%b req=%b want 0/0", instr_valid, mem_req);
    end
    reset = 1'b0; #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rm_restart req=%b addr=%h want 1/0", mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap();
    apply_reset(1);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD; #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL wr_idle_req got=%b want=0", mem_req); end
    @(negedge clk);
    redirect = 1'b0; #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_req req=%b addr=%h valid=%b want 1/fffffffc/0", mem_req, mem_addr, instr_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'h3FFF_FFFF || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wr_top valid=%b pc=%h instr=%h addr=%h want 1/fffffffc/3fffffff/0", instr_valid, instr_pc, instr, mem_addr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin
      n_fail++; $display("FAIL wr_zero valid=%b pc=%h instr=%h want 1/0/0", instr_valid, instr_pc, instr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_mid_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
